uart_sim_device: RTL and testbench
==================================

Name: uart_sim_device

Overview:
- Parametrised simulation peripheral attached to the Patmos io_uart_* bus.
- Generalises the bare testbench UART hookup into a responsive device with:
  - TX FIFO drained at a programmable character rate
  - RX FIFO fed by the bench
  - status register and sticky TX-overflow flag
- Instantiated by Patmos-level testbenches so programs can print and read characters with realistic back-pressure.

Parameters:
- DATA_W, 32, width of io_uart_wr_data / io_uart_rd_data (>= 8)
- ADDR_W, 4, width of io_uart_address
- TX_DEPTH, 8, TX FIFO entries; power of 2, >= 2
- RX_DEPTH, 8, RX FIFO entries; power of 2, >= 2
- TX_DELAY, 16, cycles per transmitted character; >= 1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- io_uart_address  in  ADDR_W  register select
- io_uart_wr_data  in  DATA_W  write data
- io_uart_rd  in  1  read strobe, one cycle
- io_uart_wr  in  1  write strobe, one cycle
- io_uart_rd_data  out  DATA_W  registered read data
- rx_inject_valid  in  1  bench offers RX byte
- rx_inject_data  in  8  RX byte
- rx_inject_ready  out  1  RX FIFO not full
- tx_out_valid  out  1  one-cycle pulse: character transmitted
- tx_out_data  out  8  transmitted character, valid with tx_out_valid
- tx_char_count  out  16  total characters transmitted, wraps at 65535 -> 0

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - FIFOs empty; io_uart_rd_data=0; tx_out_valid=0; tx_out_data=0; tx_char_count=0; tx_overflow=0; drain FSM to IDLE, counter=0.
  - Mid-operation reset aborts an in-flight character; no pulse in the reset cycle.
- Address decode:
  - address==0: STATUS; address==1: DATA.
  - Any other address: reads return 0, writes ignored.
- Read latency 1:
  - io_uart_rd in cycle N -> io_uart_rd_data updated at edge ending N, valid in N+1.
  - Value held until the next read.
- STATUS read:
  - bit0 = TX FIFO not full; bit1 = RX FIFO not empty; bit2 = tx_overflow; other bits 0.
  - A STATUS read clears tx_overflow, except when an overflow occurs in the same cycle; set wins.
- DATA read:
  - RX non-empty: pops head, returns byte zero-extended to DATA_W.
  - RX empty: returns 0, no pop.
- DATA write:
  - TX not full: pushes io_uart_wr_data[7:0]; upper bits ignored.
  - TX full: write dropped, tx_overflow set.
  - Fullness is evaluated before any same-cycle drain pop, so a write to a full FIFO is dropped even if a pop happens that cycle.
- STATUS write: ignored.
- io_uart_rd and io_uart_wr both high in the same cycle:
  - Both performed; the read reflects pre-write state.
  - An RX pop and a TX push are independent.
- RX injection:
  - rx_inject_ready = !rx_full, combinational from FIFO count.
  - Push when valid && ready.
  - Simultaneous push and pop on a non-empty RX: count unchanged, order preserved.
  - Valid held while not ready is a legal stall; no data loss.
- TX drain FSM:
  - IDLE: if TX non-empty, counter <= TX_DELAY-1, go WAIT.
  - WAIT: decrement counter. When counter==0:
    - pop head; tx_out_valid=1 for one cycle with tx_out_data=head
    - tx_char_count+1
    - go IDLE
  - Timing: a character written in cycle N into an empty FIFO with FSM in IDLE pulses in cycle N+1+TX_DELAY.
  - Back-to-back characters are spaced TX_DELAY+1 cycles (one IDLE cycle between).
- FIFO pointers: log2(depth)+1 bits. Full when MSBs differ and lower bits are equal; empty when pointers are equal. Wrap-around is transparent.

Test Plan:
- Reset, then read STATUS (address 0) -> io_uart_rd_data=0x1 next cycle; tx_char_count=0; rx_inject_ready=1.
- TX_DELAY=16; write DATA 0x41 in cycle 10 -> tx_out_valid pulse in cycle 27 with tx_out_data=0x41; tx_char_count=1.
- Burst of 10 DATA writes (0x30..0x39) into TX_DEPTH=8 -> STATUS bit2=1 and bit0=0; exactly 8 characters 0x30..0x37 emerge, spaced 17 cycles apart; a second STATUS read returns bit2=0.
- Inject 0x55, 0xAA, then DATA reads -> 0x55, 0xAA, then 0x0 with STATUS bit1=0. Inject 9 bytes into RX_DEPTH=8 -> ready low after 8; the 9th is accepted after one read.
- Same-cycle io_uart_rd (DATA) and io_uart_wr (DATA 0x5A) with RX holding 0x11 -> rd_data=0x11; 0x5A transmitted later.
- Assert reset for 1 cycle while FSM is in WAIT with 3 queued characters -> no tx_out_valid pulse for those characters; FIFOs empty; tx_char_count=0.

Source files
------------

// File: rtl/uart_sim_device.sv
// Simulation UART peripheral on the Patmos io_uart_* bus: a TX FIFO drained at a
// fixed character rate, an RX FIFO filled by the bench, and a STATUS register.
module uart_sim_device #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int TX_DELAY = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] io_uart_address,
    input  logic [DATA_W-1:0] io_uart_wr_data,
    input  logic              io_uart_rd,
    input  logic              io_uart_wr,
    output logic [DATA_W-1:0] io_uart_rd_data,
    input  logic              rx_inject_valid,
    input  logic [7:0]        rx_inject_data,
    output logic              rx_inject_ready,
    output logic              tx_out_valid,
    output logic [7:0]        tx_out_data,
    output logic [15:0]       tx_char_count,
    output logic              tx_state_o
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int CNT_W = (TX_DELAY > 1) ? $clog2(TX_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TX_DELAY - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } drain_state_e;

    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [TX_AW:0]   tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_AW:0]   tx_rd_ptr_q, tx_rd_ptr_d;
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [RX_AW:0]   rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RX_AW:0]   rx_rd_ptr_q, rx_rd_ptr_d;

    drain_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      char_count_q, char_count_d;
    logic             tx_overflow_q, tx_overflow_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic is_status, is_data;
    logic tx_push, tx_pop, tx_ovf_event, rx_push, rx_pop;
    logic [7:0] tx_head, rx_head;
    logic wr_data_unused;

    // Upper write-data bits carry no meaning for a byte-wide UART.
    assign wr_data_unused = ^(io_uart_wr_data >> 8);

    assign tx_full  = (tx_wr_ptr_q[TX_AW] != tx_rd_ptr_q[TX_AW]) &&
                      (tx_wr_ptr_q[TX_AW-1:0] == tx_rd_ptr_q[TX_AW-1:0]);
    assign tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign rx_full  = (rx_wr_ptr_q[RX_AW] != rx_rd_ptr_q[RX_AW]) &&
                      (rx_wr_ptr_q[RX_AW-1:0] == rx_rd_ptr_q[RX_AW-1:0]);
    assign rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);

    assign tx_head = tx_mem_q[tx_rd_ptr_q[TX_AW-1:0]];
    assign rx_head = rx_mem_q[rx_rd_ptr_q[RX_AW-1:0]];

    assign is_status = (io_uart_address == ADDR_W'(0));
    assign is_data   = (io_uart_address == ADDR_W'(1));

    // Fullness is judged on the pre-pop count, so a write meeting a drain pop is still dropped.
    assign tx_push      = io_uart_wr && is_data && !tx_full;
    assign tx_ovf_event = io_uart_wr && is_data && tx_full;
    assign rx_pop       = io_uart_rd && is_data && !rx_empty;

    // RX injection handshake: a byte transfers on any cycle where rx_inject_valid and
    // rx_inject_ready are both high; valid may be held across not-ready cycles without loss.
    assign rx_inject_ready = !rx_full;
    assign rx_push         = rx_inject_valid && rx_inject_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!tx_empty) begin
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    tx_pop  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_wr_ptr_d   = tx_wr_ptr_q + (TX_AW+1)'(tx_push);
        tx_rd_ptr_d   = tx_rd_ptr_q + (TX_AW+1)'(tx_pop);
        rx_wr_ptr_d   = rx_wr_ptr_q + (RX_AW+1)'(rx_push);
        rx_rd_ptr_d   = rx_rd_ptr_q + (RX_AW+1)'(rx_pop);
        char_count_d  = char_count_q + 16'(tx_pop);
        tx_overflow_d = tx_overflow_q;
        if (io_uart_rd && is_status) begin
            tx_overflow_d = 1'b0;
        end
        if (tx_ovf_event) begin
            tx_overflow_d = 1'b1;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (io_uart_rd) begin
            if (is_status) begin
                rd_data_d = DATA_W'({tx_overflow_q, !rx_empty, !tx_full});
            end else if (is_data) begin
                rd_data_d = rx_empty ? '0 : DATA_W'(rx_head);
            end else begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            char_count_q  <= '0;
            tx_overflow_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            char_count_q  <= char_count_d;
            tx_overflow_q <= tx_overflow_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (tx_push && !reset) begin
            tx_mem_q[tx_wr_ptr_q[TX_AW-1:0]] <= io_uart_wr_data[7:0];
        end
        if (rx_push && !reset) begin
            rx_mem_q[rx_wr_ptr_q[RX_AW-1:0]] <= rx_inject_data;
        end
    end

    // The pulse is decoded from the state, so it is masked while reset is asserted.
    assign tx_out_valid    = tx_pop && !reset;
    assign tx_out_data     = tx_out_valid ? tx_head : 8'h00;
    assign tx_char_count   = char_count_q;
    assign io_uart_rd_data = rd_data_q;
    assign tx_state_o      = state_q;

endmodule

// File: tb/tb_uart_sim_device.sv
// Self-checking bench for uart_sim_device: bus reads/writes, RX injection and the
// transmitted-character stream checked against expected queues.
module tb_uart_sim_device;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 8;
    localparam int TX_DELAY = 16;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] io_uart_address;
    logic [DATA_W-1:0] io_uart_wr_data;
    logic              io_uart_rd;
    logic              io_uart_wr;
    logic [DATA_W-1:0] io_uart_rd_data;
    logic              rx_inject_valid;
    logic [7:0]        rx_inject_data;
    logic              rx_inject_ready;
    logic              tx_out_valid;
    logic [7:0]        tx_out_data;
    logic [15:0]       tx_char_count;
    logic              tx_state_o;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_exp_q[$];
    int         obs_cyc_q[$];
    logic       ovf_model = 1'b0;
    int         tx_count_model = 0;
    logic [7:0] mon_exp;

    uart_sim_device #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TX_DEPTH(TX_DEPTH),
        .RX_DEPTH(RX_DEPTH), .TX_DELAY(TX_DELAY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_uart_address(io_uart_address),
        .io_uart_wr_data(io_uart_wr_data),
        .io_uart_rd(io_uart_rd),
        .io_uart_wr(io_uart_wr),
        .io_uart_rd_data(io_uart_rd_data),
        .rx_inject_valid(rx_inject_valid),
        .rx_inject_data(rx_inject_data),
        .rx_inject_ready(rx_inject_ready),
        .tx_out_valid(tx_out_valid),
        .tx_out_data(tx_out_data),
        .tx_char_count(tx_char_count),
        .tx_state_o(tx_state_o)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "global timeout");
    end

    // TX scoreboard: every pulse must match the head of exp_q
    always @(negedge clk) begin
        if (tx_out_valid === 1'b1) begin
            checks++;
            obs_cyc_q.push_back(cycle);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got pulse with data %h in cycle %0d, required no pulse", tx_out_data, cycle);
            end else begin
                mon_exp = exp_q.pop_front();
                tx_count_model++;
                if (tx_out_data !== mon_exp) begin
                    errors++;
                    $display("FAIL tx_data: got %h, required %h", tx_out_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] exp_status();
        return DATA_W'({ovf_model, rx_exp_q.size() != 0, exp_q.size() < TX_DEPTH});
    endfunction

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        io_uart_address = a;
        io_uart_wr_data = d;
        io_uart_wr      = 1'b1;
        if (a == ADDR_W'(1)) begin
            if (exp_q.size() < TX_DEPTH) exp_q.push_back(d[7:0]);
            else ovf_model = 1'b1;
        end
        tick();
        io_uart_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        io_uart_address = a;
        io_uart_rd      = 1'b1;
        tick();
        io_uart_rd = 1'b0;
        d = io_uart_rd_data;
    endtask

    task automatic check_status(input string name);
        logic [DATA_W-1:0] e, got;
        e = exp_status();
        bus_read(ADDR_W'(0), got);
        ovf_model = 1'b0;
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: status got %h, required %h", name, got, e);
        end
    endtask

    task automatic check_data_read(input string name);
        logic [DATA_W-1:0] e, got;
        e = (rx_exp_q.size() != 0) ? DATA_W'(rx_exp_q.pop_front()) : '0;
        bus_read(ADDR_W'(1), got);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: data got %h, required %h", name, got, e);
        end
    endtask

    task automatic inject(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        rx_inject_valid = 1'b1;
        rx_inject_data  = b;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = rx_inject_ready;
            tick();
        end
        rx_inject_valid = 1'b0;
        if (acc) rx_exp_q.push_back(b);
        else begin
            checks++;
            errors++;
            $display("FAIL inject_timeout: byte %h not accepted, required acceptance", b);
        end
    endtask

    task automatic wait_tx_drain(input string name);
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 400) begin
            tick();
            budget++;
        end
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d characters still pending, required 0", name, exp_q.size());
        end
        checks++;
        if (tx_char_count !== 16'(tx_count_model)) begin
            errors++;
            $display("FAIL %s_count: tx_char_count %0d, required %0d", name, tx_char_count, tx_count_model);
        end
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] got;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if (io_uart_rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h, required 0", io_uart_rd_data); end
        checks++;
        if (tx_out_valid !== 1'b0 || tx_out_data !== 8'h00) begin
            errors++; $display("FAIL reset_tx_out: valid %b data %h, required 0 00", tx_out_valid, tx_out_data);
        end
        checks++;
        if (tx_char_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d, required 0", tx_char_count); end
        checks++;
        if (rx_inject_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", rx_inject_ready); end
        checks++;
        if (tx_state_o !== 1'b0) begin errors++; $display("FAIL reset_state: got %b, required 0", tx_state_o); end
        check_status("reset_status");
        check_data_read("empty_rx_read");
        bus_read(ADDR_W'(7), got);
        checks++;
        if (got !== '0) begin errors++; $display("FAIL unmapped_read: got %h, required 0", got); end
        bus_write(ADDR_W'(2), 32'h0000_0077);
        bus_write(ADDR_W'(0), 32'h0000_0066);
        repeat (25) tick();
        check_status("ignored_writes_status");
    endtask

    task automatic test_single_char();
        int n;
        obs_cyc_q.delete();
        n = cycle;
        bus_write(ADDR_W'(1), 32'hFFFF_FF41);
        wait_tx_drain("single");
        checks++;
        if (obs_cyc_q.size() != 1) begin
            errors++; $display("FAIL single_pulses: got %0d pulses, required 1", obs_cyc_q.size());
        end else if (obs_cyc_q[0] != n + 1 + TX_DELAY) begin
            errors++; $display("FAIL single_latency: pulse in cycle %0d, required %0d", obs_cyc_q[0], n + 1 + TX_DELAY);
        end
    endtask

    task automatic test_overflow();
        obs_cyc_q.delete();
        for (int i = 0; i < 10; i++) bus_write(ADDR_W'(1), DATA_W'(8'h30 + i));
        checks++;
        if (ovf_model !== 1'b1) begin errors++; $display("FAIL ovf_model: got %b, required 1", ovf_model); end
        check_status("ovf_status_first");
        check_status("ovf_status_second");
        wait_tx_drain("burst");
        checks++;
        if (obs_cyc_q.size() != TX_DEPTH) begin
            errors++; $display("FAIL burst_pulses: got %0d, required %0d", obs_cyc_q.size(), TX_DEPTH);
        end
        for (int i = 1; i < obs_cyc_q.size(); i++) begin
            checks++;
            if (obs_cyc_q[i] - obs_cyc_q[i-1] != TX_DELAY + 1) begin
                errors++;
                $display("FAIL burst_spacing: gap %0d, required %0d", obs_cyc_q[i] - obs_cyc_q[i-1], TX_DELAY + 1);
            end
        end
    endtask

    task automatic test_rx();
        logic [7:0] ninth;
        logic [DATA_W-1:0] e, got;
        inject(8'h55);
        inject(8'hAA);
        check_data_read("rx_first");
        check_data_read("rx_second");
        check_data_read("rx_empty");
        check_status("rx_status_empty");
        for (int i = 0; i < RX_DEPTH; i++) inject(8'($urandom_range(0, 255)));
        checks++;
        if (rx_inject_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b, required 0", rx_inject_ready); end
        ninth = 8'($urandom_range(0, 255));
        rx_inject_valid = 1'b1;
        rx_inject_data  = ninth;
        tick();
        tick();
        checks++;
        if (rx_inject_ready !== 1'b0) begin errors++; $display("FAIL rx_stall_ready: got %b, required 0", rx_inject_ready); end
        // Read while the ninth byte is stalled; it must enter the cycle after
        e = DATA_W'(rx_exp_q.pop_front());
        io_uart_address = ADDR_W'(1);
        io_uart_rd      = 1'b1;
        tick();
        io_uart_rd = 1'b0;
        got = io_uart_rd_data;
        checks++;
        if (got !== e) begin errors++; $display("FAIL rx_stall_read: got %h, required %h", got, e); end
        checks++;
        if (rx_inject_ready !== 1'b1) begin errors++; $display("FAIL rx_reopen_ready: got %b, required 1", rx_inject_ready); end
        tick();
        rx_inject_valid = 1'b0;
        rx_exp_q.push_back(ninth);
        for (int i = 0; i < RX_DEPTH; i++) check_data_read("rx_drain");
        check_data_read("rx_drained_empty");
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] e, got;
        inject(8'h11);
        e = DATA_W'(rx_exp_q.pop_front());
        io_uart_address = ADDR_W'(1);
        io_uart_wr_data = {24'($urandom_range(0, 16777215)), 8'h5A};
        io_uart_rd      = 1'b1;
        io_uart_wr      = 1'b1;
        exp_q.push_back(8'h5A);
        tick();
        io_uart_rd = 1'b0;
        io_uart_wr = 1'b0;
        got = io_uart_rd_data;
        checks++;
        if (got !== e) begin errors++; $display("FAIL rdwr_read: got %h, required %h", got, e); end
        wait_tx_drain("rdwr");
        // RX push and pop in the same cycle on a non-empty FIFO
        inject(8'h21);
        e = DATA_W'(rx_exp_q.pop_front());
        rx_inject_valid = 1'b1;
        rx_inject_data  = 8'h22;
        io_uart_rd      = 1'b1;
        tick();
        io_uart_rd      = 1'b0;
        rx_inject_valid = 1'b0;
        rx_exp_q.push_back(8'h22);
        got = io_uart_rd_data;
        checks++;
        if (got !== e) begin errors++; $display("FAIL pushpop_read: got %h, required %h", got, e); end
        check_data_read("pushpop_second");
        check_status("pushpop_status");
    endtask

    task automatic test_reset_midflight();
        int n;
        n = cycle;
        bus_write(ADDR_W'(1), 32'h0000_0061);
        bus_write(ADDR_W'(1), 32'h0000_0062);
        bus_write(ADDR_W'(1), 32'h0000_0063);
        while (cycle < n + TX_DELAY + 1) tick();
        checks++;
        if (tx_state_o !== 1'b1) begin errors++; $display("FAIL midflight_state: got %b, required 1", tx_state_o); end
        exp_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tx_count_model = 0;
        ovf_model = 1'b0;
        rx_exp_q.delete();
        checks++;
        if (tx_char_count !== 16'h0) begin errors++; $display("FAIL midflight_count: got %0d, required 0", tx_char_count); end
        checks++;
        if (io_uart_rd_data !== '0) begin errors++; $display("FAIL midflight_rd_data: got %h, required 0", io_uart_rd_data); end
        check_status("midflight_status");
        repeat (3 * (TX_DELAY + 2)) tick();
        checks++;
        if (tx_char_count !== 16'h0) begin errors++; $display("FAIL midflight_quiet: count %0d, required 0", tx_char_count); end
    endtask

    initial begin
        reset           = 1'b1;
        io_uart_address = '0;
        io_uart_wr_data = '0;
        io_uart_rd      = 1'b0;
        io_uart_wr      = 1'b0;
        rx_inject_valid = 1'b0;
        rx_inject_data  = '0;
        test_reset();
        test_single_char();
        test_overflow();
        test_rx();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
